muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit. Sits directly downstream of the control unit, beside the single-cycle ALU.
- Accepts an ALUCtrl op code and two register operands, then computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Stalls the pipeline while busy and presents a one-cycle result pulse on completion.
- Non-M ops are ignored and remain the ALU's responsibility.

---
 rtl/muldiv_unit_pkg.sv | 39 +++
 rtl/muldiv_unit_sign_fix.sv | 53 +++++
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_muldiv_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, MD state encoding and op classification helpers for the
// RV32M multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [4:0] ALUCTRL_ADD    = 5'h00;
  localparam logic [4:0] ALUCTRL_SUB    = 5'h01;
  localparam logic [4:0] ALUCTRL_AND    = 5'h02;
  localparam logic [4:0] ALUCTRL_OR     = 5'h03;
  localparam logic [4:0] ALUCTRL_XOR    = 5'h04;
  localparam logic [4:0] ALUCTRL_SLL    = 5'h05;
  localparam logic [4:0] ALUCTRL_SRL    = 5'h06;
  localparam logic [4:0] ALUCTRL_SRA    = 5'h07;
  localparam logic [4:0] ALUCTRL_SLT    = 5'h08;
  localparam logic [4:0] ALUCTRL_SLTU   = 5'h09;
  localparam logic [4:0] ALUCTRL_MUL    = 5'h10;
  localparam logic [4:0] ALUCTRL_MULH   = 5'h11;
  localparam logic [4:0] ALUCTRL_MULHSU = 5'h12;
  localparam logic [4:0] ALUCTRL_MULHU  = 5'h13;
  localparam logic [4:0] ALUCTRL_DIV    = 5'h14;
  localparam logic [4:0] ALUCTRL_DIVU   = 5'h15;
  localparam logic [4:0] ALUCTRL_REM    = 5'h16;
  localparam logic [4:0] ALUCTRL_REMU   = 5'h17;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic is_md_op(input logic [4:0] op);
    return op inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU,
                      ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return op inside {ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};
  endfunction

endpackage

// File: rtl/muldiv_unit_sign_fix.sv
// Operand magnitude extraction at issue time and sign correction of the raw
// unsigned product / quotient / remainder at completion time.
module md_sign_fix
  import muldiv_unit_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic [4:0]        op,
  input  logic [BITS-1:0]   a,
  input  logic [BITS-1:0]   b,
  output logic [BITS-1:0]   a_mag,
  output logic [BITS-1:0]   b_mag,
  output logic              res_neg,
  input  logic [4:0]        fin_op,
  input  logic              fin_neg,
  input  logic [2*BITS-1:0] raw,
  output logic [BITS-1:0]   result
);

  logic              a_signed;
  logic              b_signed;
  logic              a_neg;
  logic              b_neg;
  logic [2*BITS-1:0] prod;
  logic [BITS-1:0]   quot;
  logic [BITS-1:0]   rem;

  always_comb begin
    a_signed = op inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_DIV, ALUCTRL_REM};
    b_signed = op inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_DIV, ALUCTRL_REM};
    a_neg    = a_signed & a[BITS-1];
    b_neg    = b_signed & b[BITS-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    // Remainder follows the dividend; everything else follows the sign product.
    res_neg  = (op == ALUCTRL_REM) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    prod   = fin_neg ? -raw : raw;
    quot   = raw[BITS-1:0];
    rem    = raw[2*BITS-1:BITS];
    result = '0;
    case (fin_op)
      ALUCTRL_MUL:                                    result = prod[BITS-1:0];
      ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU:    result = prod[2*BITS-1:BITS];
      ALUCTRL_DIV, ALUCTRL_DIVU:                      result = fin_neg ? -quot : quot;
      ALUCTRL_REM, ALUCTRL_REMU:                      result = fin_neg ? -rem : rem;
      default:                                        result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, one iteration per cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [4:0]      ALUCtrl,
  input  logic [BITS-1:0] rs1_i,
  input  logic [BITS-1:0] rs2_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [BITS-1:0] result_o
);

  localparam int CW = $clog2(BITS) + 1;
  localparam logic [CW-1:0] COUNT_INIT = CW'(BITS);

  md_state_t         state_reg, state_next;
  logic [CW-1:0]     counter_reg, counter_next;
  logic [4:0]        op_reg, op_next;
  logic              neg_reg, neg_next;
  logic [2*BITS:0]   acc_reg, acc_next;
  logic [BITS-1:0]   operand_reg, operand_next;
  logic [BITS-1:0]   result_reg, result_next;

  logic [BITS-1:0]   a_mag;
  logic [BITS-1:0]   b_mag;
  logic              res_neg;
  logic [BITS-1:0]   fix_result;

  logic              accept;
  logic              div_zero;
  logic              div_ovf;
  logic [BITS-1:0]   fast_result;
  logic [BITS:0]     mul_sum;
  logic [2*BITS:0]   mul_step;
  logic [BITS:0]     div_hi;
  logic [BITS:0]     div_trial;
  logic [2*BITS:0]   div_step;
  logic [2*BITS:0]   iter;

  md_sign_fix #(.BITS(BITS)) u_sign_fix (
    .op      (ALUCtrl),
    .a       (rs1_i),
    .b       (rs2_i),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .res_neg (res_neg),
    .fin_op  (op_reg),
    .fin_neg (neg_reg),
    .raw     (iter[2*BITS-1:0]),
    .result  (fix_result)
  );

  assign accept   = valid_i & is_md_op(ALUCtrl) & ~flush_i;
  assign div_zero = (rs2_i == '0);
  assign div_ovf  = (ALUCtrl == ALUCTRL_DIV || ALUCtrl == ALUCTRL_REM) &&
                    (rs1_i == {1'b1, {(BITS-1){1'b0}}}) && (rs2_i == '1);

  always_comb begin
    fast_result = '0;
    if (div_zero)
      fast_result = (ALUCtrl == ALUCTRL_DIV || ALUCtrl == ALUCTRL_DIVU) ? '1 : rs1_i;
    else if (div_ovf)
      fast_result = (ALUCtrl == ALUCTRL_DIV) ? {1'b1, {(BITS-1){1'b0}}} : '0;
  end

  // Multiply: acc = {carry, hi, multiplier}; add multiplicand into hi on lsb, shift right.
  // Divide:   acc = {partial remainder, dividend/quotient}; shift left, trial subtract.
  always_comb begin
    mul_sum   = acc_reg[2*BITS:BITS] + (acc_reg[0] ? {1'b0, operand_reg} : '0);
    mul_step  = {1'b0, mul_sum, acc_reg[BITS-1:1]};
    div_hi    = acc_reg[2*BITS-1:BITS-1];
    div_trial = div_hi - {1'b0, operand_reg};
    div_step  = (div_hi >= {1'b0, operand_reg}) ?
                {div_trial, acc_reg[BITS-2:0], 1'b1} :
                {acc_reg[2*BITS-1:0], 1'b0};
    iter      = is_div_op(op_reg) ? div_step : mul_step;
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    op_next      = op_reg;
    neg_next     = neg_reg;
    acc_next     = acc_reg;
    operand_next = operand_reg;
    result_next  = result_reg;
    stall_o      = 1'b0;
    case (state_reg)
      MD_IDLE: begin
        if (accept) begin
          stall_o      = 1'b1;
          op_next      = ALUCtrl;
          neg_next     = res_neg;
          counter_next = COUNT_INIT;
          if (is_div_op(ALUCtrl) && (div_zero || div_ovf)) begin
            result_next = fast_result;
            state_next  = MD_DONE;
          end else begin
            if (is_div_op(ALUCtrl)) begin
              acc_next     = {{(BITS+1){1'b0}}, a_mag};
              operand_next = b_mag;
            end else begin
              acc_next     = {{(BITS+1){1'b0}}, b_mag};
              operand_next = a_mag;
            end
            state_next = MD_BUSY;
          end
        end
      end
      MD_BUSY: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_next = MD_IDLE;
        end else begin
          acc_next     = iter;
          counter_next = counter_reg - 1'b1;
          if (counter_reg == {{(CW-1){1'b0}}, 1'b1}) begin
            result_next = fix_result;
            state_next  = MD_DONE;
          end
        end
      end
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= MD_IDLE;
      counter_reg <= '0;
      op_reg      <= '0;
      neg_reg     <= 1'b0;
      acc_reg     <= '0;
      operand_reg <= '0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      op_reg      <= op_next;
      neg_reg     <= neg_next;
      acc_reg     <= acc_next;
      operand_reg <= operand_next;
      result_reg  <= result_next;
    end
  end

  assign done_o   = (state_reg == MD_DONE) & ~flush_i;
  assign result_o = done_o ? result_reg : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table plus scoreboard of
// expected results and completion cycles, and hand-written abort sequences.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        flush_i;
  logic [4:0]  ALUCtrl;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          cycle;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  muldiv_unit #(.BITS(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_i),
    .flush_i  (flush_i),
    .ALUCtrl  (ALUCtrl),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done pulse must match the oldest pending result and cycle.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (done_o) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cycle=%0d actual result=%h, none expected", cyc, result_o);
      end else begin
        e = sb.pop_front();
        if (result_o !== e.res || cyc != e.cycle) begin
          errors++;
          $display("FAIL result cycle=%0d actual=%h@%0d expected=%h@%0d",
                   cyc, result_o, cyc, e.res, e.cycle);
        end else begin
          $display("done cycle=%0d result=%h", cyc, result_o);
        end
      end
    end else if (result_o !== 32'h0) begin
      errors++;
      $display("FAIL result_idle cycle=%0d actual=%h expected=00000000", cyc, result_o);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    @(posedge clk);
    #1;
    valid_i = 1'b1;
    ALUCtrl = op;
    rs1_i   = a;
    rs2_i   = b;
    sb.push_back('{exp, cyc + lat});
    $display("issue op=%h a=%h b=%h expect=%h lat=%0d", op, a, b, exp, lat);
    #1 chk("stall_accept", {31'b0, stall_o}, 32'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    ALUCtrl = ALUCTRL_DIV;
    rs1_i   = $urandom;
    rs2_i   = $urandom;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      if (k < lat) begin
        chk("stall_busy", {31'b0, stall_o}, 32'd1);
      end else begin
        chk("stall_done", {31'b0, stall_o}, 32'd0);
        chk("done_pulse", {31'b0, done_o}, 32'd1);
      end
    end
  endtask

  task automatic no_done_window(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk(name, {31'b0, done_o}, 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs.push_back('{ALUCTRL_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33});
    vecs.push_back('{ALUCTRL_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 33});
    vecs.push_back('{ALUCTRL_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33});
    vecs.push_back('{ALUCTRL_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    vecs.push_back('{ALUCTRL_DIVU,   32'd100,        32'd7,        32'd14,       33});
    vecs.push_back('{ALUCTRL_REMU,   32'd100,        32'd7,        32'd2,        33});
    vecs.push_back('{ALUCTRL_DIV,    32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 33});
    vecs.push_back('{ALUCTRL_REM,    32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE, 33});
    vecs.push_back('{ALUCTRL_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{ALUCTRL_REM,    32'd5,          32'd0,        32'd5,        1});
    vecs.push_back('{ALUCTRL_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{ALUCTRL_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1});
    vecs.push_back('{ALUCTRL_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{ALUCTRL_REMU,   32'd5,          32'd0,        32'd5,        1});
    vecs.push_back('{ALUCTRL_MUL,    32'h12345678,   32'd9,        32'hA3D70A38, 33});
    vecs.push_back('{ALUCTRL_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33});
    vecs.push_back('{ALUCTRL_REM,    32'd7,          32'hFFFFFFFE, 32'd1,        33});
    vecs.push_back('{ALUCTRL_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'd0,        33});
    vecs.push_back('{ALUCTRL_MULHU,  32'h80000000,   32'd2,        32'd1,        33});

    rst_n   = 1'b0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    ALUCtrl = ALUCTRL_ADD;
    rs1_i   = '0;
    rs2_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", {31'b0, done_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_stall", {31'b0, stall_o}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Reset in the middle of a multiply: no completion, unit back to idle.
    @(posedge clk);
    #1;
    valid_i = 1'b1; ALUCtrl = ALUCTRL_MUL; rs1_i = 32'd3; rs2_i = 32'd5;
    $display("issue op=%h a=%h b=%h then reset at cycle 10", ALUCtrl, rs1_i, rs2_i);
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("stall_after_reset", {31'b0, stall_o}, 32'd0);
    no_done_window("no_done_after_reset", 40);
    run_op(ALUCTRL_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Flush mid-divide.
    @(posedge clk);
    #1;
    valid_i = 1'b1; ALUCtrl = ALUCTRL_DIV; rs1_i = 32'd100; rs2_i = 32'd7;
    $display("issue op=%h a=%h b=%h then flush at cycle 5", ALUCtrl, rs1_i, rs2_i);
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    chk("stall_after_flush", {31'b0, stall_o}, 32'd0);
    no_done_window("no_done_after_flush", 40);

    // Flush in the fast-path completion cycle suppresses the pulse.
    @(posedge clk);
    #1;
    valid_i = 1'b1; ALUCtrl = ALUCTRL_DIV; rs1_i = 32'd5; rs2_i = 32'd0;
    $display("issue op=%h a=%h b=%h then flush in done cycle", ALUCtrl, rs1_i, rs2_i);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("done_flushed", {31'b0, done_o}, 32'd0);
    chk("result_flushed", result_o, 32'd0);
    @(posedge clk);
    #1 flush_i = 1'b0;
    chk("stall_after_done_flush", {31'b0, stall_o}, 32'd0);

    // Non-M op is ignored.
    @(posedge clk);
    #1;
    valid_i = 1'b1; ALUCtrl = ALUCTRL_ADD; rs1_i = 32'd1; rs2_i = 32'd2;
    $display("issue op=%h (non-M) a=%h b=%h", ALUCtrl, rs1_i, rs2_i);
    #1 chk("stall_non_m", {31'b0, stall_o}, 32'd0);
    @(posedge clk);
    #1 chk("stall_non_m_next", {31'b0, stall_o}, 32'd0);
    valid_i = 1'b0;
    no_done_window("no_done_non_m", 5);
    run_op(ALUCTRL_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
